inst_stream_driver: RTL
=======================

Name: inst_stream_driver

Overview:
- Synthesizable, emulator-friendly stimulus and check engine for the 5-stage MIPS cpu.
- Holds a loadable program of DEPTH instruction words and issues them to the cpu `inst` input, one per cycle.
- Drains the pipeline with NOPs, then checks stage-5 register writebacks in order against a loaded expected table.
- Reports pass/fail in hardware. Replaces the per-instruction hand-sequenced stimulus with a parametrised, restartable, self-checking engine.

Parameters:
- INST_W, 32, instruction and writeback data width.
- DEPTH, 16, program store entries (power of 2, >=2).
- CHK_DEPTH, 8, expected-writeback table entries (power of 2, >=1).
- DRAIN_CYCLES, 5, NOP cycles issued after the last program word.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_we  in  1  program-store write strobe.
- load_addr  in  $clog2(DEPTH)  program-store write address.
- load_data  in  INST_W  program word.
- exp_we  in  1  expected-table write strobe.
- exp_addr  in  $clog2(CHK_DEPTH)  expected-table write address.
- exp_reg  in  5  expected destination register.
- exp_data  in  INST_W  expected writeback value.
- prog_len  in  $clog2(DEPTH)+1  number of words to issue; sampled on start.
- exp_count  in  $clog2(CHK_DEPTH)+1  number of expected writebacks; sampled on start.
- start  in  1  one-cycle start pulse.
- wb_regwrite  in  1  cpu regwrite_s5.
- wb_reg  in  5  cpu wrreg_s5.
- wb_data  in  INST_W  cpu wrdata_s5.
- inst  out  INST_W  instruction to the cpu.
- busy  out  1  high in ISSUE and DRAIN.
- done  out  1  high in DONE.
- pass  out  1  valid while done.
- err_count  out  8  saturating mismatch count.
- first_err_idx  out  $clog2(CHK_DEPTH)+1  writeback index of the first error; all-ones if there is no error.

Behaviour:
- Reset (async assert, sync release): state IDLE; inst=0; busy=0; done=0; pass=0; err_count=0; first_err_idx=all-ones; issue pointer and writeback index are 0. Program and expected memories are not cleared.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on start, latch len=min(prog_len,DEPTH) and exp_count (clamped to CHK_DEPTH), clear counters and errors. Go to ISSUE if len>0, else to DRAIN.
- ISSUE: inst is a registered output; the first word appears the cycle after start. Each cycle inst=prog[ptr] and ptr increments. After word len-1 has issued, go to DRAIN.
- DRAIN: inst=0 (NOP) for exactly DRAIN_CYCLES cycles, then go to DONE.
- DONE: inst=0; done=1; pass=(err_count==0 && wb_idx==exp_count_latched). A start pulse here restarts as from IDLE. Otherwise the FSM holds.
- Writeback check runs only while busy, and only on cycles where wb_regwrite=1 and wb_reg!=0:
  - wb_idx<exp_count: compare wb_reg/wb_data with exp[wb_idx].
  - wb_idx>=exp_count: the writeback is extra and counts as an error.
  - Any error increments err_count (saturating at 255). The first error sets first_err_idx=wb_idx.
  - wb_idx increments on every counted writeback, saturating at CHK_DEPTH+1.
- load_we and exp_we are ignored while busy. Writes in IDLE or DONE take effect next cycle.
- start while busy is ignored.
- Reset mid-run aborts immediately to reset values.

Optional Feature:
- Macro INST_DRV_BUBBLE_EN.
- Defined: adds input port `bubbles` (3 bits), sampled on start. After each program word, ISSUE inserts `bubbles` NOP cycles before the next word (a hazard-free issue mode).
- Undefined: no port; back-to-back issue; bubbles behaves as 0.

Test Plan:
- Load 4 words (0x00421022, 0x20420014, 0x20630014, 0x00000000), prog_len=4, start -> inst shows those words on cycles 1-4 after start, then 5 NOPs. busy is high for 9 cycles, then done=1.
- exp table {($2,0x14),($3,0x14)}, exp_count=2; drive matching writebacks while busy -> pass=1, err_count=0, first_err_idx=all-ones.
- Same setup, but the second writeback carries data 0x15 -> pass=0, err_count=1, first_err_idx=1.
- exp_count=1 with two matching writebacks -> the extra writeback is counted: err_count=1, pass=0. A writeback to $0 is ignored.
- prog_len=0, start -> DRAIN only, done after 5 cycles. Also prog_len=20 with DEPTH=16 -> exactly 16 words issued.
- Drop reset to 0 mid-ISSUE -> inst=0, busy=0, done=0 asynchronously. A later start reruns the retained program. With INST_DRV_BUBBLE_EN and bubbles=2 -> two NOPs appear between successive words.

Source files
------------

// File: rtl/inst_stream_driver_if.sv
// Bus bundle between the stimulus/check engine and whatever drives or observes it.
// The bubbles field exists only when INST_DRV_BUBBLE_EN is defined.
interface inst_stream_driver_if #(
    parameter int INST_W    = 32,
    parameter int DEPTH     = 16,
    parameter int CHK_DEPTH = 8
);
    localparam int PAW = $clog2(DEPTH);
    localparam int CAW = (CHK_DEPTH > 1) ? $clog2(CHK_DEPTH) : 1;

    logic              load_we;
    logic [PAW-1:0]    load_addr;
    logic [INST_W-1:0] load_data;
    logic              exp_we;
    logic [CAW-1:0]    exp_addr;
    logic [4:0]        exp_reg;
    logic [INST_W-1:0] exp_data;
    logic [PAW:0]      prog_len;
    logic [CAW:0]      exp_count;
    logic              start;
    logic              wb_regwrite;
    logic [4:0]        wb_reg;
    logic [INST_W-1:0] wb_data;
`ifdef INST_DRV_BUBBLE_EN
    logic [2:0]        bubbles;
`endif
    logic [INST_W-1:0] inst;
    logic              busy;
    logic              done;
    logic              pass;
    logic [7:0]        err_count;
    logic [CAW:0]      first_err_idx;

    modport master (
`ifdef INST_DRV_BUBBLE_EN
        output bubbles,
`endif
        output load_we, load_addr, load_data, exp_we, exp_addr, exp_reg, exp_data,
        output prog_len, exp_count, start, wb_regwrite, wb_reg, wb_data,
        input  inst, busy, done, pass, err_count, first_err_idx
    );

    modport slave (
`ifdef INST_DRV_BUBBLE_EN
        input  bubbles,
`endif
        input  load_we, load_addr, load_data, exp_we, exp_addr, exp_reg, exp_data,
        input  prog_len, exp_count, start, wb_regwrite, wb_reg, wb_data,
        output inst, busy, done, pass, err_count, first_err_idx
    );
endinterface

// File: rtl/inst_stream_driver.sv
// Program issue + writeback check engine for the 5-stage MIPS cpu.
// Optional hazard-free bubble issue mode is enabled by defining INST_DRV_BUBBLE_EN.
module inst_stream_driver #(
    parameter int INST_W       = 32,
    parameter int DEPTH        = 16,
    parameter int CHK_DEPTH    = 8,
    parameter int DRAIN_CYCLES = 5
) (
    input  logic                clk,
    input  logic                reset,
    inst_stream_driver_if.slave bus
);
    localparam int PAW = $clog2(DEPTH);
    localparam int CAW = (CHK_DEPTH > 1) ? $clog2(CHK_DEPTH) : 1;
    localparam int DCW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

    localparam logic [PAW:0]   DEPTH_V = (PAW + 1)'(DEPTH);
    localparam logic [CAW:0]   CHK_V   = (CAW + 1)'(CHK_DEPTH);
    localparam logic [CAW:0]   WB_SAT  = (CAW + 1)'(CHK_DEPTH + 1);
    localparam logic [DCW-1:0] DRAIN_V = DCW'(DRAIN_CYCLES);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    state_e            state_q, state_d;
    logic [PAW-1:0]    ptr_q, ptr_d;
    logic [PAW:0]      len_q, len_d;
    logic [CAW:0]      exp_cnt_q, exp_cnt_d;
    logic [DCW-1:0]    drain_q, drain_d;
    logic [2:0]        bub_len_q, bub_len_d;
    logic [2:0]        bub_q, bub_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [7:0]        err_q, err_d;
    logic [CAW:0]      first_err_q, first_err_d;
    logic [CAW:0]      wb_idx_q, wb_idx_d;

    logic [INST_W-1:0] prog_mem     [DEPTH];
    logic [4:0]        exp_reg_mem  [CHK_DEPTH];
    logic [INST_W-1:0] exp_data_mem [CHK_DEPTH];

    logic              busy;
    logic [PAW:0]      len_c;
    logic [CAW:0]      exp_c;
    logic [2:0]        bub_c;
    logic [PAW-1:0]    ptr_nxt;
    logic              last_word;
    logic              wb_err;

    assign busy = (state_q == ISSUE) || (state_q == DRAIN);

    // NOTE: the storage arrays have no reset; only control state is cleared, so a
    // retained program survives reset and the arrays map onto plain RAM.
    always_ff @(posedge clk) begin
        if (bus.load_we && !busy) prog_mem[bus.load_addr] <= bus.load_data;
        if (bus.exp_we && !busy) begin
            exp_reg_mem[bus.exp_addr]  <= bus.exp_reg;
            exp_data_mem[bus.exp_addr] <= bus.exp_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            len_q       <= '0;
            exp_cnt_q   <= '0;
            drain_q     <= '0;
            bub_len_q   <= '0;
            bub_q       <= '0;
            inst_q      <= '0;
            err_q       <= '0;
            first_err_q <= '1;
            wb_idx_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            len_q       <= len_d;
            exp_cnt_q   <= exp_cnt_d;
            drain_q     <= drain_d;
            bub_len_q   <= bub_len_d;
            bub_q       <= bub_d;
            inst_q      <= inst_d;
            err_q       <= err_d;
            first_err_q <= first_err_d;
            wb_idx_q    <= wb_idx_d;
        end
    end

    always_comb begin
        len_c = (bus.prog_len > DEPTH_V) ? DEPTH_V : bus.prog_len;
        exp_c = (bus.exp_count > CHK_V) ? CHK_V : bus.exp_count;
`ifdef INST_DRV_BUBBLE_EN
        bub_c = bus.bubbles;
`else
        bub_c = 3'd0;
`endif
    end

    assign ptr_nxt   = ptr_q + PAW'(1);
    assign last_word = ({1'b0, ptr_q} == (len_q - (PAW + 1)'(1)));

    // NOTE: every _d gets its hold value first, so no path through this block can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        len_d       = len_q;
        exp_cnt_d   = exp_cnt_q;
        drain_d     = drain_q;
        bub_len_d   = bub_len_q;
        bub_d       = bub_q;
        inst_d      = inst_q;
        err_d       = err_q;
        first_err_d = first_err_q;
        wb_idx_d    = wb_idx_q;
        wb_err      = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    len_d       = len_c;
                    exp_cnt_d   = exp_c;
                    bub_len_d   = bub_c;
                    bub_d       = '0;
                    ptr_d       = '0;
                    err_d       = '0;
                    first_err_d = '1;
                    wb_idx_d    = '0;
                    if (len_c != '0) begin
                        state_d = ISSUE;
                        inst_d  = prog_mem[0];
                    end else begin
                        state_d = DRAIN;
                        inst_d  = '0;
                        drain_d = DCW'(1);
                    end
                end
            end
            ISSUE: begin
                if (bub_q != '0) begin
                    // Bubble slot: emit NOPs until the configured gap is filled.
                    if (bub_q == bub_len_q) begin
                        bub_d  = '0;
                        ptr_d  = ptr_nxt;
                        inst_d = prog_mem[ptr_nxt];
                    end else begin
                        bub_d  = bub_q + 3'd1;
                        inst_d = '0;
                    end
                end else if (last_word) begin
                    state_d = DRAIN;
                    inst_d  = '0;
                    drain_d = DCW'(1);
                end else if (bub_len_q != '0) begin
                    bub_d  = 3'd1;
                    inst_d = '0;
                end else begin
                    ptr_d  = ptr_nxt;
                    inst_d = prog_mem[ptr_nxt];
                end
            end
            DRAIN: begin
                inst_d = '0;
                if (drain_q >= DRAIN_V) state_d = DONE;
                else                    drain_d = drain_q + DCW'(1);
            end
            default: state_d = IDLE;
        endcase

        // Writebacks to $0 never reach the register file, so they are not counted.
        if (busy && bus.wb_regwrite && (bus.wb_reg != 5'd0)) begin
            if (wb_idx_q >= exp_cnt_q) wb_err = 1'b1;
            else wb_err = (exp_reg_mem[wb_idx_q[CAW-1:0]] != bus.wb_reg) ||
                          (exp_data_mem[wb_idx_q[CAW-1:0]] != bus.wb_data);
            if (wb_err) begin
                if (err_q != 8'hFF) err_d = err_q + 8'd1;
                if (err_q == 8'd0)  first_err_d = wb_idx_q;
            end
            if (wb_idx_q != WB_SAT) wb_idx_d = wb_idx_q + (CAW + 1)'(1);
        end
    end

    assign bus.inst          = inst_q;
    assign bus.busy          = busy;
    assign bus.done          = (state_q == DONE);
    assign bus.pass          = (state_q == DONE) && (err_q == 8'd0) && (wb_idx_q == exp_cnt_q);
    assign bus.err_count     = err_q;
    assign bus.first_err_idx = first_err_q;
endmodule
